// File: rtl/draw_cmd_scheduler_pkg.sv
// Shared types for the draw command scheduler: command payload, FSM state codes, range check.
package draw_cmd_scheduler_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned DIAM_W   = 8;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned STATE_W  = 3;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [DIAM_W-1:0]   diameter;
    logic [COLOUR_W-1:0] colour;
  } draw_cmd_t;

  typedef logic [STATE_W-1:0] sched_state_t;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD    = 3'd1;
  localparam logic [STATE_W-1:0] ST_START   = 3'd2;
  localparam logic [STATE_W-1:0] ST_RELEASE = 3'd3;
  localparam logic [STATE_W-1:0] ST_GAP     = 3'd4;

  // Centre must land on the visible screen.
  function automatic logic cmd_in_range(input draw_cmd_t c);
    return (c.x < X_W'(SCREEN_W)) && (c.y < Y_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/draw_cmd_scheduler_if.sv
// Command-source and shape-engine handshake bundle for the draw command scheduler.
interface draw_cmd_scheduler_if;
  import draw_cmd_scheduler_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [X_W-1:0]      cmd_centre_x;
  logic [Y_W-1:0]      cmd_centre_y;
  logic [DIAM_W-1:0]   cmd_diameter;
  logic [COLOUR_W-1:0] cmd_colour;

  logic                eng_start;
  logic                eng_done;
  logic [X_W-1:0]      eng_centre_x;
  logic [Y_W-1:0]      eng_centre_y;
  logic [DIAM_W-1:0]   eng_diameter;
  logic [COLOUR_W-1:0] eng_colour;

  // master: command source plus engine side; slave: the scheduler itself
  modport master (
    output cmd_valid, cmd_centre_x, cmd_centre_y, cmd_diameter, cmd_colour,
    input  cmd_ready,
    input  eng_start, eng_centre_x, eng_centre_y, eng_diameter, eng_colour,
    output eng_done
  );

  modport slave (
    input  cmd_valid, cmd_centre_x, cmd_centre_y, cmd_diameter, cmd_colour,
    output cmd_ready,
    output eng_start, eng_centre_x, eng_centre_y, eng_diameter, eng_colour,
    input  eng_done
  );

endinterface

// File: rtl/draw_cmd_scheduler_fifo.sv
// Command FIFO for the scheduler: power-of-2 depth, registered count/full/empty, head visible on rdata.
module draw_cmd_scheduler_fifo
  import draw_cmd_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  draw_cmd_t                      wdata,
  output draw_cmd_t                      rdata,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  draw_cmd_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_nx;

  always_comb begin
    count_nx = count;
    if (push && !pop)      count_nx = count + CW'(1);
    else if (pop && !push) count_nx = count - CW'(1);
  end

  // Storage needs no reset; only pointers and flags do.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nx;
      full  <= (count_nx == CW'(DEPTH));
      empty <= (count_nx == '0);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/draw_cmd_scheduler.sv
// Queues draw commands and sequences one shape engine through its start/done handshake.
// Optional engine watchdog: define DRAW_SCHED_TIMEOUT_EN.
module draw_cmd_scheduler
  import draw_cmd_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned MIN_GAP        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                       clk,
  input  logic                       rst_n,
  draw_cmd_scheduler_if.slave        bus,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic                       drop_pulse,
  output logic                       eng_abort,
  output logic                       timeout_err
);

  localparam int unsigned GAP_W = $clog2(MIN_GAP + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MIN_GAP < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("draw_cmd_scheduler: illegal DEPTH/MIN_GAP/TIMEOUT_CYCLES");
  end

  sched_state_t state_q, state_d;
  logic         eng_start_q, eng_start_d;
  draw_cmd_t    args_q, args_d;
  logic         drop_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  draw_cmd_t push_cmd, head_cmd;
  logic      fifo_full, fifo_empty, push, pop;

  assign push_cmd = {bus.cmd_centre_x, bus.cmd_centre_y, bus.cmd_diameter, bus.cmd_colour};
  assign push     = bus.cmd_valid && !fifo_full;
  assign pop      = (state_q == ST_LOAD);

  draw_cmd_scheduler_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (push_cmd),
    .rdata (head_cmd),
    .count (queue_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef DRAW_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             abort_d, terr_d;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    eng_start_d = eng_start_q;
    args_d      = args_q;
    drop_d      = 1'b0;
    gap_d       = gap_q;
`ifdef DRAW_SCHED_TIMEOUT_EN
    tmo_d       = tmo_q;
    abort_d     = 1'b0;
    terr_d      = timeout_err;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (cmd_in_range(head_cmd)) begin
          args_d          = head_cmd;
          args_d.diameter = {head_cmd.diameter[DIAM_W-1:1], 1'b0};
          eng_start_d     = 1'b1;
          state_d         = ST_START;
`ifdef DRAW_SCHED_TIMEOUT_EN
          tmo_d           = '0;
`endif
        end else begin
          drop_d  = 1'b1;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_START: begin
        if (bus.eng_done) begin
          eng_start_d = 1'b0;
          state_d     = ST_RELEASE;
        end
`ifdef DRAW_SCHED_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          eng_start_d = 1'b0;
          abort_d     = 1'b1;
          terr_d      = 1'b1;
          state_d     = ST_RELEASE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      ST_RELEASE: begin
        if (!bus.eng_done) begin
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(MIN_GAP - 1)) state_d = ST_IDLE;
        else                              gap_d   = gap_q + GAP_W'(1);
      end
      default: begin
        eng_start_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      eng_start_q <= 1'b0;
      args_q      <= '0;
      drop_pulse  <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      eng_start_q <= eng_start_d;
      args_q      <= args_d;
      drop_pulse  <= drop_d;
      gap_q       <= gap_d;
    end
  end

`ifdef DRAW_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q       <= '0;
      eng_abort   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tmo_q       <= tmo_d;
      eng_abort   <= abort_d;
      timeout_err <= terr_d;
    end
  end
`else
  assign eng_abort   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign bus.cmd_ready    = !fifo_full;
  assign bus.eng_start    = eng_start_q;
  assign bus.eng_centre_x = args_q.x;
  assign bus.eng_centre_y = args_q.y;
  assign bus.eng_diameter = args_q.diameter;
  assign bus.eng_colour   = args_q.colour;
  assign busy             = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_draw_cmd_scheduler.sv
// Directed bench for draw_cmd_scheduler: queue-based dispatch model plus hand-computed checks.
module tb_draw_cmd_scheduler;

  localparam int DEPTH   = 4;
  localparam int MIN_GAP = 2;
`ifdef DRAW_SCHED_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 65536;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [2:0] queue_count;
  logic       drop_pulse;
  logic       eng_abort;
  logic       timeout_err;

  draw_cmd_scheduler_if bus ();

  draw_cmd_scheduler #(.DEPTH(DEPTH), .MIN_GAP(MIN_GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .queue_count (queue_count),
    .drop_pulse  (drop_pulse),
    .eng_abort   (eng_abort),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int d; int c; bit ok; } exp_t;

  exp_t mq[$];
  exp_t cur;
  int   vectors = 0, miscompares = 0;
  int   n_starts = 0, n_drops = 0;
  bit   eng_auto = 1'b0;
  int   eng_lat = 4;
  int   eng_cnt = 0;
  bit   prev_start = 1'b0, done_seen = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Engine stand-in: raises done eng_lat cycles into a draw, drops it once start falls.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      bus.eng_done = 1'b0;
      eng_cnt = 0;
    end else if (!bus.eng_start) begin
      bus.eng_done = 1'b0;
      eng_cnt = 0;
    end else if (eng_auto && !bus.eng_done) begin
      eng_cnt++;
      if (eng_cnt >= eng_lat) bus.eng_done = 1'b1;
    end
  end

  // Compare process: every accepted command is consumed in order, either as a draw or a drop.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0;
      done_seen  = 1'b0;
    end else begin
      if (bus.eng_start && !prev_start) begin
        if (mq.size() == 0) bound_fail("start_without_cmd");
        else begin
          cur = mq.pop_front();
          check("start_cmd_in_range", int'(cur.ok), 1);
          check("eng_x", int'(bus.eng_centre_x), cur.x);
          check("eng_y", int'(bus.eng_centre_y), cur.y);
          check("eng_d", int'(bus.eng_diameter), cur.d);
          check("eng_c", int'(bus.eng_colour), cur.c);
          n_starts++;
        end
      end else if (bus.eng_start) begin
        check("args_stable", int'({bus.eng_centre_x, bus.eng_centre_y, bus.eng_diameter, bus.eng_colour}),
              (cur.x << 18) | (cur.y << 11) | (cur.d << 3) | cur.c);
      end
      if (drop_pulse) begin
        if (mq.size() == 0) bound_fail("drop_without_cmd");
        else begin
          exp_t e;
          e = mq.pop_front();
          check("drop_cmd_out_of_range", int'(e.ok), 0);
          n_drops++;
        end
      end
      if (done_seen) check("start_low_after_done", int'(bus.eng_start), 0);
      done_seen = bus.eng_start && bus.eng_done;
      check("queue_count", int'(queue_count), mq.size());
      check("cmd_ready", int'(bus.cmd_ready), int'(mq.size() < DEPTH));
      if (mq.size() > 0 || bus.eng_start) check("busy_active", int'(busy), 1);
`ifndef DRAW_SCHED_TIMEOUT_EN
      check("abort_tied", int'({eng_abort, timeout_err}), 0);
`endif
      if (bus.cmd_valid && bus.cmd_ready) begin
        exp_t n;
        n.x  = int'(bus.cmd_centre_x);
        n.y  = int'(bus.cmd_centre_y);
        n.d  = int'(bus.cmd_diameter) - (int'(bus.cmd_diameter) % 2);
        n.c  = int'(bus.cmd_colour);
        n.ok = (n.x < 160) && (n.y < 120);
        mq.push_back(n);
      end
      prev_start = bus.eng_start;
    end
  end

  task automatic push(input int x, input int y, input int d, input int c);
    int n = 0;
    @(posedge clk);
    #1;
    bus.cmd_valid    = 1'b1;
    bus.cmd_centre_x = 8'(x);
    bus.cmd_centre_y = 7'(y);
    bus.cmd_diameter = 8'(d);
    bus.cmd_colour   = 3'(c);
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 3000);
    if (!bus.cmd_ready) bound_fail("push_accept");
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!bus.eng_start && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.eng_start) bound_fail("wait_start");
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || bus.eng_start) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (mq.size() != 0 || bus.eng_start) bound_fail("drain");
    repeat (8) @(negedge clk);
    check("busy_idle", int'(busy), 0);
    check("queue_empty_idle", int'(queue_count), 0);
  endtask

  initial begin
    int s0, d0, n;
    bus.cmd_valid = 1'b0;
    bus.cmd_centre_x = '0; bus.cmd_centre_y = '0;
    bus.cmd_diameter = '0; bus.cmd_colour = '0;
    bus.eng_done = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_eng_start", int'(bus.eng_start), 0);
    check("rst_queue_count", int'(queue_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_drop", int'(drop_pulse), 0);
    check("rst_abort_err", int'({eng_abort, timeout_err}), 0);
    check("rst_args", int'({bus.eng_centre_x, bus.eng_centre_y, bus.eng_diameter, bus.eng_colour}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: latency and argument hand-off
    eng_auto = 1'b1;
    push(80, 60, 80, 2);
    @(negedge clk);
    check("lat_n_start", int'(bus.eng_start), 0);
    check("lat_n_count", int'(queue_count), 1);
    @(negedge clk);
    check("lat_n1_start", int'(bus.eng_start), 0);
    @(negedge clk);
    check("lat_n2_start", int'(bus.eng_start), 1);
    check("lat_args", int'({bus.eng_centre_x, bus.eng_centre_y, bus.eng_diameter, bus.eng_colour}),
          (80 << 18) | (60 << 11) | (80 << 3) | 2);
    drain();

    // 2: stalled engine, FIFO fills, order preserved
    eng_auto = 1'b0;
    push(1, 2, 10, 1);
    wait_start();
`ifndef DRAW_SCHED_TIMEOUT_EN
    repeat (200) @(negedge clk);
    check("start_held_no_timeout", int'(bus.eng_start), 1);
`endif
    push(11, 12, 20, 2);
    push(21, 22, 30, 3);
    push(31, 32, 40, 4);
    push(41, 42, 50, 5);
    @(negedge clk);
    check("full_count", int'(queue_count), 4);
    check("full_ready", int'(bus.cmd_ready), 0);
    fork
      push(51, 52, 60, 6);
      begin
        repeat (8) @(negedge clk);
        check("still_full_ready", int'(bus.cmd_ready), 0);
        eng_auto = 1'b1;
      end
    join
    drain();
    check("stall_seq_last_x", cur.x, 51);

    // 3: out-of-range command dropped, next one dispatched
    s0 = n_starts; d0 = n_drops;
    push(160, 60, 40, 1);
    push(10, 10, 40, 1);
    drain();
    check("drop_count", n_drops - d0, 1);
    check("drop_starts", n_starts - s0, 1);
    check("after_drop_x", cur.x, 10);

    // 4: diameter LSB, zero diameter, screen corners
    push(50, 50, 81, 3);
    drain();
    check("diam_81_cleared", cur.d, 80);
    s0 = n_starts;
    push(20, 20, 0, 4);
    push(0, 0, 30, 5);
    push(159, 119, 30, 6);
    push(159, 120, 30, 7);
    drain();
    check("corner_starts", n_starts - s0, 3);
    check("corner_last_y", cur.y, 119);

    // 5: reset in the middle of a draw
    eng_auto = 1'b0;
    push(30, 40, 20, 5);
    wait_start();
    push(50, 50, 10, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_start", int'(bus.eng_start), 0);
    check("midrst_count", int'(queue_count), 0);
    check("midrst_busy", int'(busy), 0);
    mq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    eng_auto = 1'b1;
    s0 = n_starts;
    push(100, 100, 60, 7);
    drain();
    check("post_reset_start", n_starts - s0, 1);

`ifdef DRAW_SCHED_TIMEOUT_EN
    // 6: watchdog aborts a stuck engine
    eng_auto = 1'b0;
    push(70, 70, 20, 2);
    wait_start();
    n = 0;
    while (!eng_abort && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!eng_abort) bound_fail("wait_abort");
    check("abort_cycle", n, 100);
    check("abort_start_low", int'(bus.eng_start), 0);
    check("timeout_err_set", int'(timeout_err), 1);
    @(negedge clk);
    check("abort_one_cycle", int'(eng_abort), 0);
    eng_auto = 1'b1;
    push(71, 71, 20, 3);
    drain();
    check("timeout_err_sticky", int'(timeout_err), 1);
`else
    n = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
    $fatal(1, "watchdog");
  end

endmodule
